// File: rtl/axistream_packet_arbiter_if.sv
// Bundle of the per-source AXI-stream inputs and the shared AXI-stream output
// around the packet arbiter. The slave modport is the arbiter's view; the
// master modport is the surrounding logic (sources plus the shared consumer).
interface axistream_packet_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4,
    parameter int ID_WIDTH   = 2
);
    logic [NUM_SRC-1:0]            src_tvalid;
    logic [NUM_SRC-1:0]            src_tready;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata;
    logic [NUM_SRC-1:0]            src_tlast;

    logic                          dest_tvalid;
    logic                          dest_tready;
    logic [DATA_WIDTH-1:0]         dest_tdata;
    logic                          dest_tlast;
    logic [ID_WIDTH-1:0]           dest_tid;

    modport master (
        output src_tvalid,
        output src_tdata,
        output src_tlast,
        input  src_tready,
        input  dest_tvalid,
        input  dest_tdata,
        input  dest_tlast,
        input  dest_tid,
        output dest_tready
    );

    modport slave (
        input  src_tvalid,
        input  src_tdata,
        input  src_tlast,
        output src_tready,
        output dest_tvalid,
        output dest_tdata,
        output dest_tlast,
        output dest_tid,
        input  dest_tready
    );
endinterface

// File: rtl/axistream_packet_arbiter.sv
// Round-robin packet arbiter: shares one AXI-stream output between NUM_SRC
// packetised sources. A grant is taken in IDLE and held until the granted
// source's tlast beat is accepted, so packets never interleave. While locked
// the granted source is passed straight through with no added latency.
module axistream_packet_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic clk,
    input  logic rst,
    axistream_packet_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ID_WIDTH-1:0]   grant;
    logic [ID_WIDTH-1:0]   grant_next;
    logic [ID_WIDTH-1:0]   pointer;
    logic [ID_WIDTH-1:0]   pointer_next;

    // Arbitration datapath
    logic [2*NUM_SRC-1:0]  req_double;
    logic [NUM_SRC-1:0]    req_rot;
    logic [NUM_SRC-1:0]    req_first;
    logic [ID_WIDTH-1:0]   offset;
    logic [ID_WIDTH:0]     winner_sum;
    logic [ID_WIDTH-1:0]   winner;
    logic                  any_req;

    // Granted-source passthrough
    logic [NUM_SRC-1:0]    grant_onehot;
    logic [DATA_WIDTH-1:0] granted_data;
    logic                  granted_valid;
    logic                  granted_last;
    logic                  lock_active;
    logic                  accept;
    logic [ID_WIDTH-1:0]   pointer_after;

    // Rotate the request vector so bit 0 is the source the pointer names;
    // the lowest set bit of the rotated vector is then the round-robin winner.
    assign req_double = {bus.src_tvalid, bus.src_tvalid};
    assign req_rot    = NUM_SRC'(req_double >> pointer);
    assign req_first  = req_rot & (~req_rot + NUM_SRC'(1));
    assign any_req    = |req_first;

    // One-hot to binary encode of the winning offset from the pointer.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_offset
        logic [ID_WIDTH-1:0] acc;
        if (k == 0) begin : g_first
            assign acc = '0;
        end else begin : g_rest
            assign acc = g_offset[k-1].acc | (req_first[k] ? ID_WIDTH'(k) : '0);
        end
    end
    assign offset = g_offset[NUM_SRC-1].acc;

    // Map the offset back to a source index, wrapping at NUM_SRC rather than
    // at 2**ID_WIDTH so unused index codes can never be granted.
    assign winner_sum = {1'b0, pointer} + {1'b0, offset};
    assign winner     = (winner_sum >= (ID_WIDTH+1)'(NUM_SRC))
                        ? ID_WIDTH'(winner_sum - (ID_WIDTH+1)'(NUM_SRC))
                        : winner_sum[ID_WIDTH-1:0];

    // Select the granted source's stream signals.
    assign grant_onehot  = NUM_SRC'(1) << grant;
    assign granted_data  = DATA_WIDTH'(bus.src_tdata >> (int'(grant) * DATA_WIDTH));
    assign granted_valid = |(bus.src_tvalid & grant_onehot);
    assign granted_last  = |(bus.src_tlast & grant_onehot);

    // Reset overrides the lock immediately so no beat slips through while rst is high.
    assign lock_active   = (state == LOCKED) && !rst;
    assign accept        = lock_active && granted_valid && bus.dest_tready;
    assign pointer_after = (grant == ID_WIDTH'(NUM_SRC - 1)) ? '0 : grant + ID_WIDTH'(1);

    // Drive the shared output and the per-source readies from the current lock.
    always_comb begin
        bus.dest_tvalid = 1'b0;
        bus.src_tready  = '0;
        bus.dest_tdata  = granted_data;
        bus.dest_tlast  = granted_last;
        bus.dest_tid    = grant;
        if (lock_active) begin
            bus.dest_tvalid = granted_valid;
            bus.src_tready  = bus.dest_tready ? grant_onehot : '0;
        end
    end

    // Next-state logic: lock onto the winner from IDLE, release after the tlast beat.
    always_comb begin
        state_next   = state;
        grant_next   = grant;
        pointer_next = pointer;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = LOCKED;
                    grant_next = winner;
                end
            end
            LOCKED: begin
                if (accept && granted_last) begin
                    state_next   = IDLE;
                    pointer_next = pointer_after;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            pointer <= '0;
        end else begin
            state   <= state_next;
            grant   <= grant_next;
            pointer <= pointer_next;
        end
    end

endmodule

// File: tb/tb_axistream_packet_arbiter.sv
// Bench for the round-robin packet arbiter. Source beats are queued per
// source and fed by an AXI-stream driver; the expected output order is pushed
// to a scoreboard as stimulus is queued and checked as beats leave the DUT.
module tb_axistream_packet_arbiter;

    localparam int DATA_WIDTH = 8;
    localparam int NUM_SRC    = 4;
    localparam int ID_WIDTH   = 2;

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } src_beat_t;

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   tid;
        logic                  last;
    } exp_beat_t;

    logic clk = 1'b0;
    logic rst;

    axistream_packet_arbiter_if #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_SRC(NUM_SRC),
        .ID_WIDTH(ID_WIDTH)
    ) bus ();

    axistream_packet_arbiter #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_SRC(NUM_SRC),
        .ID_WIDTH(ID_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    src_beat_t                     src_q [NUM_SRC][$];
    exp_beat_t                     exp_q [$];
    bit                            src_gap [NUM_SRC];
    logic [NUM_SRC-1:0]            fired = '0;
    logic [NUM_SRC-1:0]            valid_vec;
    logic [NUM_SRC*DATA_WIDTH-1:0] data_vec;
    logic [NUM_SRC-1:0]            last_vec;

    int compare_count  = 0;
    int mismatch_count = 0;
    int cycle_count    = 0;

    bit check_gap        = 1'b0;
    bit have_prev        = 1'b0;
    bit prev_was_last    = 1'b0;
    bit last_accepted    = 1'b0;
    int prev_accept_cycle = 0;
    bit mon_accept;
    exp_beat_t mon_exp;

    // Count a comparison and report it when it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, observed, expected, cycle_count);
        end
    endtask

    // Queue one expected output beat in the order the arbiter should emit it.
    task automatic expectBeat(input int src, input int data, input bit last);
        exp_beat_t e;
        e.data = DATA_WIDTH'(data);
        e.tid  = ID_WIDTH'(src);
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Queue a packet of consecutive data bytes on one source; the first
    // n_expect beats are also pushed to the scoreboard.
    task automatic applyStimulus(input int src, input int base, input int n_beats, input int n_expect);
        src_beat_t b;
        for (int k = 0; k < n_beats; k++) begin
            b.data = DATA_WIDTH'(base + k);
            b.last = (k == n_beats - 1);
            src_q[src].push_back(b);
            if (k < n_expect) expectBeat(src, base + k, b.last);
        end
    endtask

    task automatic resetDut();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Wait until every expected beat has been seen, within a cycle budget.
    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checkOutput("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Wait for the first accepted beat, within a cycle budget.
    task automatic waitFirstAccept(input string tag, output bit found);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (bus.dest_tvalid && bus.dest_tready) found = 1'b1;
        end
        checkOutput(tag, found, 1);
    endtask

    // Record which sources handed over a beat this cycle.
    always @(negedge clk) begin
        fired = bus.src_tvalid & bus.src_tready;
    end

    // Source driver: retire accepted beats, then present each source's next beat.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (fired[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0 && !src_gap[i]) begin
                valid_vec[i]                         = 1'b1;
                data_vec[i*DATA_WIDTH +: DATA_WIDTH] = src_q[i][0].data;
                last_vec[i]                          = src_q[i][0].last;
            end else begin
                valid_vec[i]                         = 1'b0;
                data_vec[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                last_vec[i]                          = 1'b0;
            end
        end
        bus.src_tvalid = valid_vec;
        bus.src_tdata  = data_vec;
        bus.src_tlast  = last_vec;
    end

    // Output monitor: scoreboard compare, dead cycle after tlast, beat spacing.
    always @(negedge clk) begin
        cycle_count++;
        if (!check_gap) have_prev = 1'b0;
        mon_accept = bus.dest_tvalid && bus.dest_tready;
        if (last_accepted) checkOutput("bubble_after_tlast", bus.dest_tvalid, 0);
        if (mon_accept) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_beat", 1, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("beat_data", bus.dest_tdata, mon_exp.data);
                checkOutput("beat_tid", bus.dest_tid, mon_exp.tid);
                checkOutput("beat_last", bus.dest_tlast, mon_exp.last);
            end
            if (check_gap && have_prev)
                checkOutput("beat_spacing", cycle_count - prev_accept_cycle, prev_was_last ? 2 : 1);
            have_prev         = 1'b1;
            prev_accept_cycle = cycle_count;
            prev_was_last     = bus.dest_tlast;
        end
        last_accepted = mon_accept && bus.dest_tlast;
    end

    // Watchdog in case the DUT wedges something the bounded waits miss.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [3:0] ready_pat;
    bit         found;

    // Test sequence.
    initial begin
        rst             = 1'b1;
        bus.dest_tready = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) src_gap[i] = 1'b0;

        // Reset with all sources requesting, then release: source 0 first.
        $display("[TB] reset with all sources valid");
        for (int s = 0; s < NUM_SRC; s++) applyStimulus(s, 'hC0 + s, 1, 1);
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_dest_tvalid", bus.dest_tvalid, 0);
            checkOutput("rst_src_tready", bus.src_tready, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("release_idle_cycle", bus.dest_tvalid, 0);
        @(negedge clk);
        checkOutput("release_first_valid", bus.dest_tvalid, 1);
        checkOutput("release_first_tid", bus.dest_tid, 0);
        waitDrain(100);

        // Single 3-beat packet from source 2: one bubble, three beats, idle.
        $display("[TB] single source packet");
        resetDut();
        @(negedge clk);
        applyStimulus(2, 'hA1, 3, 3);
        @(negedge clk);
        checkOutput("single_bubble", bus.dest_tvalid, 0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("single_burst_valid", bus.dest_tvalid, 1);
        end
        @(negedge clk);
        checkOutput("single_end_idle", bus.dest_tvalid, 0);
        waitDrain(50);

        // Round-robin: all sources busy with 2-beat packets, two rounds.
        $display("[TB] round robin");
        resetDut();
        @(negedge clk);
        check_gap = 1'b1;
        for (int rep = 0; rep < 2; rep++)
            for (int s = 0; s < NUM_SRC; s++)
                applyStimulus(s, 'h40 + rep * 'h10 + s * 2, 2, 2);
        waitDrain(200);
        check_gap = 1'b0;

        // No interleave: source 1 stalls mid-packet while source 3 waits.
        $display("[TB] no interleave");
        resetDut();
        @(negedge clk);
        applyStimulus(1, 'h80, 3, 3);
        applyStimulus(3, 'h90, 2, 2);
        waitFirstAccept("lock_first_accept", found);
        checkOutput("lock_first_tid", bus.dest_tid, 1);
        src_gap[1] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("gap_src3_ready", bus.src_tready[3], 0);
            checkOutput("gap_dest_tvalid", bus.dest_tvalid, 0);
            checkOutput("gap_tid_held", bus.dest_tid, 1);
        end
        src_gap[1] = 1'b0;
        waitDrain(100);

        // Backpressure on a source-0 packet with dest_tready pattern 1,0,0,1.
        $display("[TB] backpressure");
        resetDut();
        @(negedge clk);
        applyStimulus(0, 'h60, 4, 4);
        ready_pat = 4'b1001;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1 bus.dest_tready = ready_pat[k % 4];
            @(negedge clk);
            if (bus.dest_tvalid) begin
                checkOutput("bp_ready_mirror", bus.src_tready[0], bus.dest_tready);
                checkOutput("bp_other_ready", bus.src_tready[NUM_SRC-1:1], 0);
            end
        end
        @(posedge clk);
        #1 bus.dest_tready = 1'b1;
        waitDrain(100);

        // Reset while source 1 presents beat 2 of 4; remainder becomes a new packet.
        $display("[TB] reset mid packet");
        resetDut();
        @(negedge clk);
        applyStimulus(1, 'hB0, 4, 1);
        waitFirstAccept("rst_mid_first_accept", found);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_dest_tvalid", bus.dest_tvalid, 0);
        checkOutput("rst_mid_src_tready", bus.src_tready, 0);
        applyStimulus(0, 'hD0, 2, 2);
        expectBeat(1, 'hB1, 1'b0);
        expectBeat(1, 'hB2, 1'b0);
        expectBeat(1, 'hB3, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_idle", bus.dest_tvalid, 0);
        @(negedge clk);
        checkOutput("rst_mid_first_valid", bus.dest_tvalid, 1);
        checkOutput("rst_mid_first_tid", bus.dest_tid, 0);
        waitDrain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
